// File: rtl/cnn_pkg.sv
// Shared constants and FSM encoding for the CNN image feeder.
// No ports; imported by the feeder, its interface, its sub-module and the bench.
package cnn_pkg;

  localparam int PIXELS  = 784;  // pixels per image (28x28)
  localparam int DW      = 32;   // signed pixel word width
  localparam int CLASSES = 10;   // width of the CNN class vector
  localparam int AW      = 10;   // buffer address width
  localparam int IW      = 4;    // class-index width

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2,
    RESULT    = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/cnn_image_feeder_if.sv
// Pixel-stream link between the image feeder and the CNN top.
//   cnn_start      feeder -> CNN  start level
//   cnn_din        feeder -> CNN  pixel word (registered in the feeder)
//   cnn_din_ready  CNN -> feeder  request for the next pixel
//   cnn_done       CNN -> feeder  classification complete
//   cnn_classes    CNN -> feeder  class vector, valid with cnn_done
interface cnn_image_feeder_if;
  import cnn_pkg::*;

  logic                  cnn_start;
  logic signed [DW-1:0]  cnn_din;
  logic                  cnn_din_ready;
  logic                  cnn_done;
  logic [CLASSES-1:0]    cnn_classes;

  modport master (
    output cnn_start, cnn_din,
    input  cnn_din_ready, cnn_done, cnn_classes
  );

  modport slave (
    input  cnn_start, cnn_din,
    output cnn_din_ready, cnn_done, cnn_classes
  );
endinterface

// File: rtl/class_index_enc.sv
// Lowest-set-bit encoder over a CLASSES-wide class vector.
//   vec         in   class vector
//   idx         out  index of lowest set bit, all-ones when vec is zero
//   not_onehot  out  high unless exactly one bit of vec is set
module class_index_enc
  import cnn_pkg::*;
(
  input  logic [CLASSES-1:0] vec,
  output logic [IW-1:0]      idx,
  output logic               not_onehot
);

  logic [IW-1:0] ones;

  always_comb begin
    idx  = '1;
    ones = '0;
    // Scan downward so the last hit (lowest index) wins.
    for (int i = CLASSES - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
    for (int i = 0; i < CLASSES; i++) begin
      ones = ones + IW'(vec[i]);
    end
    not_onehot = (ones != IW'(1));
  end

endmodule

// File: rtl/cnn_image_feeder.sv
// Buffers one image from the host and streams it to the CNN, one pixel per
// cnn_din_ready edge, then captures and decodes the classification result.
//   clk, rst                      clock, async active-high reset
//   wr_en, wr_addr, wr_data       host buffer write port (IDLE/RESULT only)
//   go                            one-cycle stream request
//   busy                          high from accepted go until RESULT
//   cnn                           pixel-stream link to the CNN (master side)
//   result_valid/_onehot/_class   captured classification result
//   err_overrun, err_early        sticky stream protocol errors
//   err_class                     captured vector was not one-hot
//
// state     | meaning
// IDLE      | after reset; host may load the buffer
// STREAM    | sending pixels on each ready edge
// WAIT_DONE | all pixels sent; waiting for cnn_done
// RESULT    | result held; host may reload and restart
module cnn_image_feeder
  import cnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [DW-1:0] wr_data,
  input  logic                 go,
  output logic                 busy,
  cnn_image_feeder_if.master   cnn,
  output logic                 result_valid,
  output logic [CLASSES-1:0]   result_onehot,
  output logic [IW-1:0]        result_class,
  output logic                 err_overrun,
  output logic                 err_early,
  output logic                 err_class
);

  feeder_state_t state_q, state_d;

  logic signed [DW-1:0] pix_buf [PIXELS];
  logic [AW-1:0]        rd_ptr;
  logic                 host_access;
  logic                 start_stream, load_pix, overrun, capture;
  logic [IW-1:0]        enc_idx;
  logic                 enc_bad;

  class_index_enc u_enc (
    .vec        (cnn.cnn_classes),
    .idx        (enc_idx),
    .not_onehot (enc_bad)
  );

  assign host_access = (state_q == IDLE) || (state_q == RESULT);

  // Buffer contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_en && host_access && (wr_addr < AW'(PIXELS)))
      pix_buf[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    start_stream  = 1'b0;
    load_pix      = 1'b0;
    overrun       = 1'b0;
    capture       = 1'b0;
    busy          = 1'b0;
    cnn.cnn_start = 1'b0;
    result_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d      = STREAM;
          start_stream = 1'b1;
        end
      end
      STREAM: begin
        busy          = 1'b1;
        cnn.cnn_start = 1'b1;
        // done outranks ready: the pointer freezes where the CNN stopped.
        if (cnn.cnn_done) begin
          capture = 1'b1;
          state_d = RESULT;
        end else if (cnn.cnn_din_ready) begin
          load_pix = 1'b1;
          if (rd_ptr == AW'(PIXELS - 1)) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        busy          = 1'b1;
        cnn.cnn_start = 1'b1;
        overrun       = cnn.cnn_din_ready;
        if (cnn.cnn_done) begin
          capture = 1'b1;
          state_d = RESULT;
        end
      end
      RESULT: begin
        result_valid = 1'b1;
        if (go) begin
          state_d      = STREAM;
          start_stream = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr        <= '0;
      cnn.cnn_din   <= '0;
      result_onehot <= '0;
      result_class  <= '1;
      err_overrun   <= 1'b0;
      err_early     <= 1'b0;
      err_class     <= 1'b0;
    end else begin
      if (start_stream) begin
        rd_ptr      <= '0;
        err_overrun <= 1'b0;
        err_early   <= 1'b0;
        err_class   <= 1'b0;
      end
      if (load_pix) begin
        cnn.cnn_din <= pix_buf[rd_ptr];
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (overrun) begin
        err_overrun <= 1'b1;
        cnn.cnn_din <= '0;
      end
      if (capture) begin
        result_onehot <= cnn.cnn_classes;
        result_class  <= enc_idx;
        err_class     <= enc_bad;
        if (state_q == STREAM) err_early <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnn_image_feeder.sv
// Directed/randomized bench for cnn_image_feeder with a pixel-count reference model.
module tb_cnn_image_feeder;
  import cnn_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [DW-1:0] wr_data;
  logic                 go;
  logic                 busy;
  logic                 result_valid;
  logic [CLASSES-1:0]   result_onehot;
  logic [IW-1:0]        result_class;
  logic                 err_overrun, err_early, err_class;

  cnn_image_feeder_if cnn_bus ();

  cnn_image_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .go            (go),
    .busy          (busy),
    .cnn           (cnn_bus),
    .result_valid  (result_valid),
    .result_onehot (result_onehot),
    .result_class  (result_class),
    .err_overrun   (err_overrun),
    .err_early     (err_early),
    .err_class     (err_class)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: image contents and number of pixels handed to the CNN.
  logic signed [DW-1:0] model_buf [PIXELS];
  int                   sent;
  logic signed [DW-1:0] last_din;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] ref_class(input logic [CLASSES-1:0] v);
    logic [CLASSES-1:0] lowest;
    lowest = v & (~v + 1'b1);
    for (int i = 0; i < CLASSES; i++)
      if (lowest == (CLASSES'(1) << i)) return IW'(i);
    return '1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input bit ramp);
    for (int i = 0; i < PIXELS; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = ramp ? DW'(i) : $signed($urandom);
      model_buf[i] = wr_data;
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic start_image(input string tag);
    go = 1'b1;
    tick();
    go = 1'b0;
    sent = 0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_start"}, cnn_bus.cnn_start, 1);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_errs"}, {err_overrun, err_early, err_class}, 0);
  endtask

  // Drive ready with probability pct until the model has sent stop_at pixels.
  task automatic stream(input string tag, input int pct, input int stop_at, input int budget);
    bit r;
    for (int c = 0; c < budget && sent < stop_at; c++) begin
      r = ($urandom_range(99) < pct);
      cnn_bus.cnn_din_ready = r;
      tick();
      if (r) begin
        last_din = model_buf[sent];
        sent++;
      end
      check({tag, "_din"}, cnn_bus.cnn_din, last_din);
    end
    cnn_bus.cnn_din_ready = 1'b0;
    check({tag, "_count"}, sent, stop_at);
  endtask

  task automatic finish_done(input string tag, input logic [CLASSES-1:0] v, input bit early);
    cnn_bus.cnn_done    = 1'b1;
    cnn_bus.cnn_classes = v;
    tick();
    cnn_bus.cnn_done = 1'b0;
    check({tag, "_valid"}, result_valid, 1);
    check({tag, "_onehot"}, result_onehot, v);
    check({tag, "_class"}, result_class, ref_class(v));
    check({tag, "_errclass"}, err_class, ($countones(v) != 1));
    check({tag, "_early"}, err_early, early);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, cnn_bus.cnn_start, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, cnn_bus.cnn_start, 0);
    check({tag, "_din"}, cnn_bus.cnn_din, 0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_onehot"}, result_onehot, 0);
    check({tag, "_class"}, result_class, 4'hF);
    check({tag, "_errs"}, {err_overrun, err_early, err_class}, 0);
  endtask

  initial begin
    logic [CLASSES-1:0]   v;
    logic signed [DW-1:0] newpix;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0;
    cnn_bus.cnn_din_ready = 1'b0; cnn_bus.cnn_done = 1'b0; cnn_bus.cnn_classes = '0;
    sent = 0; last_din = '0;
    #12;
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;
    tick();

    // Ramp image, continuous ready.
    load_image(1'b1);
    start_image("go1");
    stream("ramp", 100, PIXELS, PIXELS + 10);
    check("ramp_busy", busy, 1);
    check("ramp_errs", {err_overrun, err_early, err_class}, 0);
    finish_done("done1", 10'b0000100000, 1'b0);

    // Random image, ~50% ready, with ignored go and ignored write mid-stream.
    load_image(1'b0);
    start_image("go2");
    stream("rnd_a", 50, 50, 1000);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("go_ignored_busy", busy, 1);
    check("go_ignored_din", cnn_bus.cnn_din, last_din);
    wr_en = 1'b1; wr_addr = AW'(sent + 5); wr_data = ~model_buf[sent + 5];
    tick();
    wr_en = 1'b0;
    check("wr_ignored_din", cnn_bus.cnn_din, last_din);
    stream("rnd_b", 50, PIXELS, 4000);
    cnn_bus.cnn_din_ready = 1'b1;
    tick();
    cnn_bus.cnn_din_ready = 1'b0;
    check("overrun_flag", err_overrun, 1);
    check("overrun_din", cnn_bus.cnn_din, 0);
    check("overrun_busy", busy, 1);
    last_din = '0;
    finish_done("done2", 10'b0000000000, 1'b0);
    check("overrun_sticky", err_overrun, 1);

    // Write coinciding with go from RESULT; early done together with ready.
    newpix = $signed($urandom);
    wr_en = 1'b1; wr_addr = '0; wr_data = newpix; go = 1'b1;
    model_buf[0] = newpix;
    tick();
    wr_en = 1'b0; go = 1'b0; sent = 0;
    check("go3_busy", busy, 1);
    check("go3_errs", {err_overrun, err_early, err_class}, 0);
    stream("early", 100, 100, 200);
    cnn_bus.cnn_din_ready = 1'b1;
    finish_done("done3", 10'b0000100100, 1'b1);
    check("early_frozen_din", cnn_bus.cnn_din, model_buf[99]);
    tick();
    tick();
    cnn_bus.cnn_din_ready = 1'b0;
    check("result_ready_din", cnn_bus.cnn_din, model_buf[99]);
    check("result_ready_overrun", err_overrun, 0);

    // Async reset mid-stream, then restart from pixel 0 with buffer intact.
    start_image("go4");
    stream("pre_rst", 70, 300, 2000);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    rst = 1'b0;
    tick();
    last_din = '0;
    start_image("go5");
    stream("post_rst", 100, PIXELS, PIXELS + 10);
    v = CLASSES'(1) << $urandom_range(CLASSES - 1);
    finish_done("done5", v, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_image_feeder.md
Name: cnn_image_feeder

Overview:
- Transmit-side partner of the CNN pixel-stream interface.
- A host loads one image (PIXELS words) into an internal buffer. On `go`, the block asserts `cnn_start` and supplies one pixel on `cnn_din` for each cycle `cnn_din_ready` is high.
- On `cnn_done`, it captures `cnn_classes`, decodes the class index, and holds the result for the host.
- Sits between the host/loader logic and the CNN top.

Parameters:
- PIXELS, 784, number of pixels per image (28x28).
- DW, 32, pixel word width (signed).
- CLASSES, 10, width of the CNN class vector.
- AW, 10, buffer address width (2^AW >= PIXELS).
- IW, 4, class-index width (2^IW > CLASSES).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  host buffer write strobe.
- wr_addr  in  AW  host write address, 0..PIXELS-1.
- wr_data  in  DW  host pixel data.
- go  in  1  one-cycle request to stream the buffered image.
- busy  out  1  high from accepted `go` until RESULT is entered.
- cnn_start  out  1  start level to CNN.
- cnn_din  out  DW  pixel to CNN, registered.
- cnn_din_ready  in  1  CNN requests the next pixel.
- cnn_done  in  1  CNN classification complete.
- cnn_classes  in  CLASSES  CNN class vector, sampled when `cnn_done`=1.
- result_valid  out  1  result fields valid.
- result_onehot  out  CLASSES  captured class vector.
- result_class  out  IW  index of lowest set bit of the captured vector; all-ones if the vector is zero.
- err_overrun  out  1  sticky; `cnn_din_ready` seen after PIXELS pixels were sent.
- err_early  out  1  sticky; `cnn_done` seen before PIXELS pixels were sent.
- err_class  out  1  captured vector was not exactly one-hot.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; rd_ptr=0.
  - All outputs are 0 except `result_class`, which resets to all-ones.
  - Buffer contents are not reset.
- Buffer:
  - PIXELS x DW register array, combinational read at rd_ptr.
  - Write when wr_en=1, wr_addr<PIXELS and state is IDLE or RESULT; otherwise ignored.
- FSM states: IDLE, STREAM, WAIT_DONE, RESULT.
  - IDLE: on `go`, go to STREAM; rd_ptr=0; clear result_valid and all err flags. `busy` and `cnn_start` go high on the next cycle.
  - STREAM: `cnn_start`=1. On each edge with `cnn_din_ready`=1, do `cnn_din`<=buf[rd_ptr] and rd_ptr+=1. After the edge that loads pixel PIXELS-1, go to WAIT_DONE. Pixel k is therefore visible the cycle after the (k+1)-th ready edge, matching the CNN's sampling.
  - WAIT_DONE: `cnn_start`=1. A ready edge sets err_overrun and loads `cnn_din`=0. On `cnn_done`=1, go to RESULT.
  - RESULT: `busy`=0, `cnn_start`=0, result_valid=1, result fields held. `go` restarts exactly as from IDLE.
- Capture on the `cnn_done` edge:
  - result_onehot<=cnn_classes.
  - result_class<=index of lowest set bit (all-ones if zero).
  - err_class<=(popcount != 1).
  - result_valid rises the next cycle.
- Early done: `cnn_done`=1 in STREAM captures the result as above, sets err_early, and goes to RESULT.
- Simultaneous events:
  - `cnn_done` and `cnn_din_ready` on the same edge in STREAM: capture the result, do not advance rd_ptr.
  - `go` while busy: ignored.
  - wr_en coinciding with `go` in IDLE/RESULT: the write is performed first, so it is visible to pixel 0 onward.
- `cnn_din` holds its last value when `cnn_din_ready`=0.
- No arithmetic on pixel data; pass-through only.

Decomposition:
- Shared package `cnn_pkg` holds:
  - constants: PIXELS, DW, CLASSES, IW;
  - FSM state encoding: IDLE=0, STREAM=1, WAIT_DONE=2, RESULT=3.
- One natural sub-module, `class_index_enc`: a combinational lowest-set-bit encoder over CLASSES bits with a not-one-hot flag. Reusable by the bench and the display logic.

Test Plan:
- Load buf[i]=i; `go`; hold `cnn_din_ready`=1 for 784 cycles -> `cnn_din` steps 0,1,..,783, one per cycle starting the cycle after the first ready edge; state becomes WAIT_DONE; err flags 0.
- Toggle `cnn_din_ready` pseudo-randomly (~50%) -> `cnn_din` changes only after ready edges; sequence is still 0..783 with no repeats or skips.
- After streaming, `cnn_done`=1 with `cnn_classes`=10'b0000100000 -> result_valid=1, result_class=5, err_class=0, busy=0, cnn_start=0.
- `cnn_classes`=10'b0000000000 -> result_class=4'hF, err_class=1. With 10'b0000100100 -> result_class=2, err_class=1.
- `cnn_done` after 100 pixels -> err_early=1, RESULT entered, rd_ptr frozen at 100. An extra ready in WAIT_DONE -> err_overrun=1, `cnn_din`=0.
- Assert rst mid-STREAM (pixel 300) -> all outputs 0 immediately (result_class=4'hF). A following `go` restarts at pixel 0 with buffer contents intact.
